// File: rtl/harness_pkg.sv
// Shared helpers for the serdes test harness: counter sizing, output FSM states, parity.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. Parity framing is selected by HARNESS_PARITY_EN in the modules that import this.
package harness_pkg;

  // Output serialiser FSM encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Widest word the parity helper accepts; callers zero-extend into it (zeros do not change parity)
  localparam int PARITY_MAX_W = 1024;

  // Bits needed to count 0..n-1, never less than one
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Even-parity bit: 1 when the word holds an odd number of ones
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/harness_serialiser.sv
// Snapshots dut_out on capture_req and shifts it out MSB-first (plus even parity under HARNESS_PARITY_EN).
// Latency: first valid bit 1 cycle after the capture edge; frame lasts exactly one cycle per bit, no gaps.
// Backpressure: none; capture_req outside IDLE (including the last shift cycle) is dropped, never queued.
module harness_serialiser
  import harness_pkg::*;
#(
  parameter int OUT_WIDTH = 60
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [OUT_WIDTH-1:0] dut_out,
  input  logic                 capture_req,
  output logic                 test_out,
  output logic                 test_out_valid,
  output logic                 out_busy
);

`ifdef HARNESS_PARITY_EN
  localparam int FRAME = OUT_WIDTH + 1;
`else
  localparam int FRAME = OUT_WIDTH;
`endif
  localparam int             CW   = cnt_width(FRAME);
  localparam logic [CW-1:0]  LAST = CW'(FRAME - 1);

  logic             state;
  logic [FRAME-1:0] shifter;
  logic [CW-1:0]    cnt;
  logic [FRAME-1:0] load_word;

  // Frame image loaded at capture: data, then the parity bit trailing the LSB when enabled
  always_comb begin
    load_word = '0;
`ifdef HARNESS_PARITY_EN
    load_word = {dut_out, even_parity(PARITY_MAX_W'(dut_out))};
`else
    load_word = dut_out;
`endif
  end

  // Output FSM: IDLE waits for a capture, SHIFT runs a fixed-length frame then returns to IDLE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      shifter <= '0;
      cnt     <= '0;
    end else if (state == ST_IDLE) begin
      if (capture_req) begin
        shifter <= load_word;
        cnt     <= '0;
        state   <= ST_SHIFT;
      end
    end else begin
      // Zero fill means the shifter is empty again when the frame ends, so test_out idles low
      shifter <= {shifter[FRAME-2:0], 1'b0};
      if (cnt == LAST) begin
        cnt   <= '0;
        state <= ST_IDLE;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // All outputs come straight from flops
  assign test_out       = shifter[FRAME-1];
  assign test_out_valid = (state == ST_SHIFT);
  assign out_busy       = (state == ST_SHIFT);

endmodule

// File: rtl/harness_serdes_framed.sv
// Pin-limited DUT harness: framed serial stimulus -> atomic parallel dut_in; dut_out snapshot -> serial test_out.
// Latency: dut_in updates 1 cycle after the final frame bit; test_out starts 1 cycle after capture_req.
// Backpressure: none; gaps via test_in_valid, partial frames never land. HARNESS_PARITY_EN adds parity + in_parity_err.
module harness_serdes_framed
  import harness_pkg::*;
#(
  parameter int                  IN_WIDTH  = 60,
  parameter int                  OUT_WIDTH = 60,
  parameter logic [IN_WIDTH-1:0] IN_RESET  = {IN_WIDTH{1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 test_in,
  input  logic                 test_in_valid,
  output logic [IN_WIDTH-1:0]  dut_in,
  output logic                 dut_in_update,
  input  logic [OUT_WIDTH-1:0] dut_out,
  input  logic                 capture_req,
  output logic                 test_out,
  output logic                 test_out_valid,
  output logic                 out_busy
`ifdef HARNESS_PARITY_EN
  ,
  output logic                 in_parity_err
`endif
);

`ifdef HARNESS_PARITY_EN
  localparam int IN_FRAME = IN_WIDTH + 1;
`else
  localparam int IN_FRAME = IN_WIDTH;
`endif
  localparam int            CW       = cnt_width(IN_FRAME);
  localparam logic [CW-1:0] LAST_BIT = CW'(IN_FRAME - 1);

  logic [IN_WIDTH-1:0] in_shift;
  logic [CW-1:0]       in_cnt;
  logic [IN_WIDTH-1:0] in_next;

  assign in_next = {in_shift[IN_WIDTH-2:0], test_in};

  // Input deserialiser: gaps hold everything; dut_in only changes when a whole frame has arrived
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_shift      <= IN_RESET;
      in_cnt        <= '0;
      dut_in        <= IN_RESET;
      dut_in_update <= 1'b0;
`ifdef HARNESS_PARITY_EN
      in_parity_err <= 1'b0;
`endif
    end else begin
      dut_in_update <= 1'b0;
`ifdef HARNESS_PARITY_EN
      in_parity_err <= 1'b0;
`endif
      if (test_in_valid) begin
        if (in_cnt == LAST_BIT) in_cnt <= '0;
        else                    in_cnt <= in_cnt + CW'(1);
`ifdef HARNESS_PARITY_EN
        // Final bit is parity over the data already in the shifter; it is never shifted in
        if (in_cnt == LAST_BIT) begin
          if (even_parity(PARITY_MAX_W'(in_shift)) == test_in) begin
            dut_in        <= in_shift;
            dut_in_update <= 1'b1;
          end else begin
            in_parity_err <= 1'b1;
          end
        end else begin
          in_shift <= in_next;
        end
`else
        in_shift <= in_next;
        if (in_cnt == LAST_BIT) begin
          dut_in        <= in_next;
          dut_in_update <= 1'b1;
        end
`endif
      end
    end
  end

  harness_serialiser #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_ser (
    .clock         (clock),
    .reset_n       (reset_n),
    .dut_out       (dut_out),
    .capture_req   (capture_req),
    .test_out      (test_out),
    .test_out_valid(test_out_valid),
    .out_busy      (out_busy)
  );

endmodule
